// File: rtl/player_input_pkg.sv
// Shared definitions for the player input controller: event kinds,
// register addresses and event word layout.
package player_input_pkg;

  typedef enum logic [1:0] {
    EV_BET  = 2'd0,
    EV_CALL = 2'd1,
    EV_FOLD = 2'd2
  } ev_kind_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CMD    = 2'd3;

  localparam int EV_KIND_LSB = 0;
  localparam int EV_KIND_W   = 2;
  localparam int EV_BET_LSB  = 2;
  localparam int EV_BET_W    = 6;

  // One FIFO entry; only the fields that reach the bus are stored.
  typedef struct packed {
    logic [EV_BET_W-1:0] bet;
    ev_kind_e            kind;
  } ev_t;

  // Expand a stored entry into the 32-bit EVENT register word.
  function automatic logic [31:0] ev_word(ev_t e);
    logic [31:0] w;
    w = '0;
    w[EV_KIND_LSB +: EV_KIND_W] = e.kind;
    w[EV_BET_LSB  +: EV_BET_W]  = e.bet;
    return w;
  endfunction

endpackage

// File: rtl/player_input_ctrl_debounce.sv
// Two-flop synchronizer plus stability counter for one raw input.
// evt pulses for the cycle in which the debounced level moves to the
// non-idle (active) value.
module input_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic IDLE            = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          db;
  logic [CW-1:0] cnt;
  logic          upd;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset_n) sync <= {2{IDLE}};
    else          sync <= {sync[0], raw};
  end

  assign upd = (sync[1] != db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign evt = upd && (sync[1] != IDLE);

  // Count consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db  <= IDLE;
      cnt <= '0;
    end else if (sync[1] == db) begin
      cnt <= '0;
    end else if (upd) begin
      db  <= sync[1];
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/player_input_ctrl.sv
// Player input controller: debounced buttons/switch turned into bet, call
// and fold events, queued in a small FIFO and read by Nios over Avalon-MM.
module player_input_ctrl
  import player_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  key_n,
  input  logic [9:0]  sw,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  // Source index matches ev_kind_e: 0 bet (key0), 1 call (key1), 2 fold (sw9).
  localparam logic [2:0] IDLE_V  = 3'b011;

  logic [2:0]          raw_in, src_evt, pend, grant;
  logic [5:0]          sw_s1, sw_s2, bet_val;
  ev_t                 push_ev;
  logic                push, pop, wr_ok, drop, flush, clr_ovf, wr_cmd;
  logic                enable, irq_en, ovf, empty, full;
  ev_t                 mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic [4:0]          count5;
  logic                unused_ok;

  assign unused_ok = ^{sw[8:6], avs_writedata[31:2]};
  assign raw_in    = {sw[9], key_n[1], key_n[0]};

  for (genvar i = 0; i < 3; i++) begin : g_db
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE           (IDLE_V[i])
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_in[i]),
      .evt    (src_evt[i])
    );
  end

  // Bet value only needs synchronizing; it is sampled well after it settles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw[5:0];
      sw_s2 <= sw_s1;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign count5  = 5'(count);
  assign wr_cmd  = avs_write && (avs_address == ADDR_CMD);
  assign flush   = wr_cmd && avs_writedata[1];
  assign clr_ovf = wr_cmd && avs_writedata[0];
  assign pop     = avs_read && (avs_address == ADDR_EVENT) && !empty;
  assign push    = (|grant) && enable;
  assign wr_ok   = push && !flush && (!full || pop);
  assign drop    = push && !flush && full && !pop;

  // Fixed-priority pick fold > bet > call; only bet events carry the switch value.
  always_comb begin
    grant        = '0;
    push_ev.kind = EV_BET;
    push_ev.bet  = '0;
    if (pend[2]) begin
      grant[2]     = 1'b1;
      push_ev.kind = EV_FOLD;
    end else if (pend[0]) begin
      grant[0]     = 1'b1;
      push_ev.kind = EV_BET;
      push_ev.bet  = bet_val;
    end else if (pend[1]) begin
      grant[1]     = 1'b1;
      push_ev.kind = EV_CALL;
    end
  end

  // Pending flags: a fresh edge beats the clear from a same-cycle push.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend    <= '0;
      bet_val <= '0;
    end else if (flush || !enable) begin
      pend    <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (src_evt[i])    pend[i] <= 1'b1;
        else if (grant[i]) pend[i] <= 1'b0;
      end
      if (src_evt[0]) bet_val <= sw_s2;
    end
  end

  // FIFO storage; contents are don't-care until count covers them.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_ev;
  end

  // FIFO pointers and occupancy; flush overrides any same-cycle push.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control register, sticky overflow and the registered interrupt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (avs_write && (avs_address == ADDR_CTRL)) begin
        enable <= avs_writedata[0];
        irq_en <= avs_writedata[1];
      end
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      irq <= irq_en && !empty;
    end
  end

  // Read data, one cycle after the strobe; idle cycles return zero.
  always_ff @(posedge clk) begin
    if (!reset_n || !avs_read) begin
      avs_readdata <= '0;
    end else begin
      case (avs_address)
        ADDR_STATUS: avs_readdata <= {24'd0, ovf, full, empty, count5};
        ADDR_EVENT:  avs_readdata <= empty ? 32'd0 : ev_word(mem[rd_ptr]);
        ADDR_CTRL:   avs_readdata <= {30'd0, irq_en, enable};
        default:     avs_readdata <= '0;
      endcase
    end
  end

endmodule

// File: doc/player_input_ctrl.md
PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles before a debounced input changes (10 ms at 50 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1: sole clock, 50 MHz system clock.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port key_n, input, 2: raw push-buttons, active-low, asynchronous; key_n[0] = bet confirm, key_n[1] = call.
REQ-006 SHALL have port sw, input, 10: raw slide switches, asynchronous; sw[5:0] = bet value, sw[9] = tilt/fold.
REQ-007 SHALL have port avs_address, input, 2: Avalon-MM word address.
REQ-008 SHALL have ports avs_read, input, 1 and avs_write, input, 1: Avalon-MM strobes, single-cycle, never both high.
REQ-009 SHALL have port avs_writedata, input, 32: write data.
REQ-010 SHALL have port avs_readdata, output, 32: read data, registered, read latency 1.
REQ-011 SHALL have port irq, output, 1: level interrupt to Nios, registered.

Function
REQ-012 Each of key_n[0], key_n[1], sw[9] SHALL pass a 2-FF synchronizer and then a debouncer; sw[5:0] SHALL pass a 2-FF synchronizer only.
REQ-013 Debouncer output SHALL take the synchronized value once that value has differed from the output for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 Event sources: bet = debounced key_n[0] 1->0; call = debounced key_n[1] 1->0; fold = debounced sw[9] 0->1.
REQ-015 On a source edge with CTRL.enable=1, that source's pending flag SHALL set and its bet field SHALL capture synchronized sw[5:0] in the same cycle.
REQ-016 The arbiter SHALL push at most one pending event per cycle, fixed priority fold > bet > call, and clear only the pushed source's flag.
REQ-017 Event word: [1:0] kind (0 bet, 1 call, 2 fold), [7:2] captured bet value, [31:8] zero.
REQ-018 Push when FIFO full SHALL drop the event, clear its pending flag and set sticky STATUS.overflow.
REQ-019 Simultaneous push and pop SHALL be allowed at any occupancy, including full; count unchanged.
REQ-020 Register map: 0 STATUS (RO) [4:0] count, [5] empty, [6] full, [7] overflow; 1 EVENT (RO, pop); 2 CTRL (RW) [0] enable, [1] irq_en; 3 CMD (WO) [0] clear overflow, [1] flush.
REQ-021 Read of EVENT when non-empty SHALL return the head and pop it; when empty SHALL return 0 with no state change.
REQ-022 Reads of address 3 and writes to addresses 0/1 SHALL return 0 / be ignored.
REQ-023 CMD.flush SHALL empty the FIFO and clear all pending flags in one cycle and win over a same-cycle push.
REQ-024 CTRL.enable=0 SHALL clear pending flags and block new events; debouncers keep running; FIFO contents retained.
REQ-025 irq SHALL equal registered (irq_en AND NOT empty), one cycle after the change.
REQ-026 Event first-readable latency: 1 cycle after the debounced edge (flag set), plus 1 cycle per higher-priority pending event.

Reset
REQ-027 While reset_n=0 at a clk edge: FIFO empty, pointers 0, pending flags 0, overflow 0, enable 0, irq_en 0, avs_readdata 0, irq 0.
REQ-028 Debounced outputs SHALL reset to idle (keys 1, sw[9] 0) with counters 0; synchronizers SHALL reset to the same idle values.
REQ-029 Reset asserted mid-operation SHALL discard FIFO contents and in-flight debounce counts with no event emitted.

Structure
REQ-030 Shared package player_input_pkg SHALL hold the event-kind enum, register address constants and event field widths/offsets.
REQ-031 Debouncer SHALL be a sub-module input_debounce (synchronizer + counter), instantiated three times.
REQ-032 FIFO SHALL be inline registers (no vendor RAM).

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8)
REQ-033 enable=1, sw[5:0]=0x15, key_n[0] held low 10 cycles -> one EVENT=0x00000054; STATUS count 1->0 after the read.
REQ-034 key_n[0] toggles every 2 cycles for 20 cycles then returns high -> zero events.
REQ-035 fold, bet and call edges debounced in the same cycle -> EVENT reads 0x2, 0x0|bet<<2, 0x1 in that order.
REQ-036 9 call events with no reads -> count 8, full=1, overflow=1; 8 reads each 0x1; 9th read 0; CMD=0x1 clears overflow.
REQ-037 irq_en=1, one event -> irq high 1 cycle after push; EVENT read -> irq low 1 cycle after pop; CMD flush with 3 queued -> count 0.
REQ-038 reset_n low 1 cycle with 5 queued events -> STATUS=0x20, CTRL=0, irq=0, no event from the interrupted debounce.
